// File: rtl/pudding_dac_loader.sv
// Host-side loader for the PUDDING current-DAC daisychain. It generates tclk and the
// datum/shift/transfer/dir/enable pin sequences for write, readback and target reset.
module pudding_dac_loader #(
  parameter int HALF_PERIOD = 2,
  parameter int NBITS       = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [NBITS-1:0] cmd_wdata,
  input  logic             dac_enable,
  output logic             done,
  output logic             err,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic             tclk,
  output logic             trst_n,
  output logic             t_datum,
  output logic             t_shift,
  output logic             t_transfer,
  output logic             t_dir,
  output logic             t_en,
  input  logic             t_sdo
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE_SHIFT, S_WRITE_COMMIT, S_READ, S_TRESET, S_FINISH
  } state_t;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_TRESET = 2'd2;
  localparam logic [7:0] PH_LAST   = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] BIT_LAST  = 8'(NBITS - 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       ph_q, ph_d;
  logic             hi_q, hi_d;
  logic [7:0]       bit_q, bit_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [NBITS-1:0] rdata_q, rdata_d;
  logic             tclk_q, tclk_d;
  logic             trst_n_q, trst_n_d;
  logic             datum_q, datum_d;
  logic             shift_q, shift_d;
  logic             transfer_q, transfer_d;
  logic             dir_q, dir_d;
  logic             en_q, en_d;
  logic             accept;
  logic             last;

  assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_FINISH);
  assign busy       = ~cmd_ready;
  assign done       = (state_q == S_FINISH);
  assign err        = done && (op_q == 2'd3);
  assign accept     = cmd_valid && cmd_ready;
  assign rdata      = rdata_q;
  assign tclk       = tclk_q;
  assign trst_n     = trst_n_q;
  assign t_datum    = datum_q;
  assign t_shift    = shift_q;
  assign t_transfer = transfer_q;
  assign t_dir      = dir_q;
  assign t_en       = en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      ph_q       <= '0;
      hi_q       <= 1'b0;
      bit_q      <= '0;
      sh_q       <= '0;
      rdata_q    <= '0;
      tclk_q     <= 1'b0;
      trst_n_q   <= 1'b1;
      datum_q    <= 1'b0;
      shift_q    <= 1'b0;
      transfer_q <= 1'b0;
      dir_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ph_q       <= ph_d;
      hi_q       <= hi_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rdata_q    <= rdata_d;
      tclk_q     <= tclk_d;
      trst_n_q   <= trst_n_d;
      datum_q    <= datum_d;
      shift_q    <= shift_d;
      transfer_q <= transfer_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
    end
  end

  // sh_q shifts write data out MSB first, or collects readback bits LSB-in.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ph_d       = ph_q;
    hi_d       = hi_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    rdata_d    = rdata_q;
    tclk_d     = tclk_q;
    trst_n_d   = trst_n_q;
    datum_d    = datum_q;
    shift_d    = shift_q;
    transfer_d = transfer_q;
    dir_d      = dir_q;
    en_d       = en_q;
    last       = 1'b0;

    case (state_q)
      S_IDLE:   en_d = dac_enable;
      S_FINISH: state_d = S_IDLE;
      default: begin
        if (ph_q != PH_LAST) begin
          ph_d = ph_q + 8'd1;
        end else begin
          ph_d   = '0;
          hi_d   = ~hi_q;
          tclk_d = ~hi_q;
          if (hi_q) begin
            if (state_q == S_READ) sh_d = {sh_q[NBITS-2:0], t_sdo};
            last = (state_q == S_WRITE_COMMIT) ||
                   ((state_q == S_READ) && (bit_q == BIT_LAST)) ||
                   ((state_q == S_TRESET) && (bit_q == 8'd1));
            if (last) begin
              state_d    = S_FINISH;
              datum_d    = 1'b0;
              shift_d    = 1'b0;
              transfer_d = 1'b0;
              dir_d      = 1'b0;
              trst_n_d   = 1'b1;
              if (state_q == S_READ) rdata_d = {sh_q[NBITS-2:0], t_sdo};
            end else begin
              bit_d = bit_q + 8'd1;
              en_d  = dac_enable;
              if (state_q == S_READ) begin
                shift_d    = 1'b1;
                transfer_d = 1'b0;
              end else if (state_q == S_WRITE_SHIFT) begin
                if (bit_q == BIT_LAST) begin
                  state_d    = S_WRITE_COMMIT;
                  shift_d    = 1'b0;
                  transfer_d = 1'b1;
                  dir_d      = 1'b1;
                  datum_d    = 1'b0;
                end else begin
                  datum_d = sh_q[NBITS-1];
                  sh_d    = {sh_q[NBITS-2:0], 1'b0};
                end
              end
            end
          end
        end
      end
    endcase

    if (accept) begin
      op_d       = cmd_op;
      ph_d       = '0;
      hi_d       = 1'b0;
      bit_d      = '0;
      tclk_d     = 1'b0;
      en_d       = dac_enable;
      trst_n_d   = (cmd_op != OP_TRESET);
      datum_d    = 1'b0;
      shift_d    = 1'b0;
      transfer_d = 1'b0;
      dir_d      = 1'b0;
      sh_d       = '0;
      case (cmd_op)
        OP_WRITE: begin
          state_d = S_WRITE_SHIFT;
          shift_d = 1'b1;
          datum_d = cmd_wdata[NBITS-1];
          sh_d    = {cmd_wdata[NBITS-2:0], 1'b0};
        end
        OP_READ: begin
          state_d    = S_READ;
          transfer_d = 1'b1;
        end
        OP_TRESET: state_d = S_TRESET;
        default:   state_d = S_FINISH;
      endcase
    end
  end

endmodule

// File: tb/tb_pudding_dac_loader.sv
// Bench for pudding_dac_loader: behavioural PUDDING target on tclk plus a period-schedule
// model of the expected pin sequence, checked every cycle on the falling clk edge.
module tb_pudding_dac_loader;
  localparam int H   = 2;
  localparam int NB  = 128;
  localparam int PER = 2 * H;

  logic          clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, dac_enable = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [NB-1:0] cmd_wdata = '0;
  logic          cmd_ready, done, err, busy, tclk, trst_n;
  logic          t_datum, t_shift, t_transfer, t_dir, t_en, t_sdo;
  logic [NB-1:0] rdata;

  pudding_dac_loader #(.HALF_PERIOD(H), .NBITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .dac_enable(dac_enable),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .tclk(tclk), .trst_n(trst_n),
    .t_datum(t_datum), .t_shift(t_shift), .t_transfer(t_transfer), .t_dir(t_dir),
    .t_en(t_en), .t_sdo(t_sdo)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural target: pins sampled on tclk rising edge.
  logic [NB-1:0] tgt_chain, tgt_state;
  int n_tclk = 0, n_shift = 0, n_commit = 0;
  initial begin
    tgt_chain = {$urandom, $urandom, $urandom, $urandom};
    tgt_state = {$urandom, $urandom, $urandom, $urandom};
  end
  always @(posedge tclk) begin
    n_tclk <= n_tclk + 1;
    if (!trst_n) begin
      tgt_chain <= '0;
      tgt_state <= '0;
    end else if (t_transfer) begin
      if (t_dir) begin
        tgt_state <= tgt_chain;
        n_commit  <= n_commit + 1;
      end else begin
        tgt_chain <= tgt_state;
      end
    end else if (t_shift) begin
      tgt_chain <= {tgt_chain[NB-2:0], t_datum};
      n_shift   <= n_shift + 1;
    end
  end
  assign t_sdo = tgt_chain[NB-1];

  function automatic int periods(input logic [1:0] op);
    case (op)
      2'd0:    return NB + 1;
      2'd1:    return NB;
      2'd2:    return 2;
      default: return 0;
    endcase
  endfunction

  // Model: m_t is the cycle offset since the accept edge (1 = first low cycle).
  logic          m_on = 1'b0, m_act = 1'b0, m_en = 1'b0;
  int            m_t = 0;
  logic [1:0]    m_op = 2'd0;
  logic [NB-1:0] m_w = '0, m_commit = '0, m_rdata = '0;

  always @(negedge clk) begin : model_chk
    logic [10:0] ev, av;
    int p, ph, dt;
    logic rdy;
    dt = periods(m_op) * PER + 1;
    if (m_on) begin
      ev = {1'b0, 1'b1, 5'b00000, 4'b0001};
      ev[4] = m_en;
      if (m_act) begin
        if (m_t == dt) begin
          ev[3] = 1'b1;
          ev[2] = (m_op == 2'd3);
        end else begin
          ev[1] = 1'b1;
          ev[0] = 1'b0;
          p  = (m_t - 1) / PER;
          ph = (m_t - 1) % PER;
          ev[10] = (ph >= H);
          case (m_op)
            2'd0: if (p < NB) begin ev[7] = 1'b1; ev[8] = m_w[NB-1-p]; end
                  else begin ev[6] = 1'b1; ev[5] = 1'b1; end
            2'd1: if (p == 0) ev[6] = 1'b1; else ev[7] = 1'b1;
            2'd2: ev[9] = 1'b0;
            default: ;
          endcase
        end
      end
      av = {tclk, trst_n, t_datum, t_shift, t_transfer, t_dir, t_en, done, err, busy, cmd_ready};
      chk("pins", NB'(av), NB'(ev));
      chk("rdata", rdata, m_rdata);
      if (m_act && m_t == dt) chk("target_state", tgt_state, m_commit);
    end
    if (!rst_n) begin
      m_on = 1'b1; m_act = 1'b0; m_en = 1'b0; m_rdata = '0;
    end else if (m_on) begin
      rdy = !m_act || (m_t == dt);
      if (cmd_valid && rdy) begin
        m_act = 1'b1; m_t = 1; m_op = cmd_op; m_w = cmd_wdata; m_en = dac_enable;
      end else if (!m_act) begin
        m_en = dac_enable;
      end else if (m_t == dt) begin
        m_act = 1'b0;
      end else begin
        if ((m_t % PER == 0) && (m_t + 1 < dt)) m_en = dac_enable;
        m_t++;
      end
      if (m_act && m_t == periods(m_op) * PER + 1) begin
        case (m_op)
          2'd0: m_commit = m_w;
          2'd1: m_rdata = m_commit;
          2'd2: m_commit = '0;
          default: ;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) dac_enable = ~dac_enable;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [NB-1:0] wd, output int acc);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 2000);
    if (n >= 2000) chk("accept_timeout", 1, 0);
    step();
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  // Returns at the falling edge of the done cycle; lat counts the done cycle itself.
  task automatic wait_done(input int acc, output int lat, output int nlow);
    int n = 0;
    lat = -1; nlow = 0;
    while (n < 1000) begin
      @(negedge clk); n++;
      if (!trst_n) nlow++;
      if (done) begin lat = cyc - acc + 1; break; end
    end
    if (lat < 0) chk("done_timeout", 1, 0);
  endtask

  logic [NB-1:0] w_a, w_b, w1, w2;
  int acc, acc2, lat, nlow, s0, c0, k0, n, nd;
  logic [1:0] rop;

  initial begin
    w_a = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    w_b = 128'hDEADBEEF_0123_4567_89AB_CDEF_F0E1D2C3;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs", NB'({cmd_ready, busy, done, tclk, trst_n}), NB'(5'b10001));
    step();

    send(2'd2, '0, acc);
    wait_done(acc, lat, nlow);
    chk("treset_latency", NB'(lat), NB'(9));
    chk("treset_low_cycles", NB'(nlow), NB'(4 * H));
    chk("treset_chain", tgt_chain, '0);
    step();
    @(negedge clk);
    chk("treset_done_once", NB'(done), NB'(0));
    step();

    s0 = n_shift; c0 = n_commit;
    send(2'd0, w_a, acc);
    wait_done(acc, lat, nlow);
    chk("write_latency", NB'(lat), NB'(517));
    chk("write_shift_periods", NB'(n_shift - s0), NB'(128));
    chk("write_commit_periods", NB'(n_commit - c0), NB'(1));
    chk("write_state_a", tgt_state, w_a);
    step();

    send(2'd0, w_b, acc);
    wait_done(acc, lat, nlow);
    step();
    send(2'd1, '0, acc);
    wait_done(acc, lat, nlow);
    chk("read_latency", NB'(lat), NB'(513));
    chk("read_word", rdata, w_b);
    chk("read_state_kept", tgt_state, w_b);
    step();

    // Second command held during busy; accepted in the done cycle.
    w1 = {$urandom, $urandom, $urandom, $urandom};
    send(2'd0, w1, acc);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    wait_done(acc, lat, nlow);
    chk("b2b_first_latency", NB'(lat), NB'(517));
    step();
    cmd_valid = 1'b0;
    acc2 = cyc;
    @(negedge clk);
    chk("b2b_no_gap", NB'({busy, done}), NB'(2'b10));
    wait_done(acc2, lat, nlow);
    chk("b2b_read_latency", NB'(lat), NB'(513));
    chk("b2b_read_word", rdata, w1);
    step();

    // Abort a write at bit 60.
    w2 = ~w1;
    send(2'd0, w2, acc);
    repeat (60 * PER) @(posedge clk);
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_outputs", NB'({tclk, trst_n, t_datum, t_shift, t_transfer, t_dir, t_en, done, err, busy, cmd_ready}),
        NB'(11'b01000000001));
    chk("abort_rdata", rdata, '0);
    nd = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", NB'(nd), NB'(0));
    chk("abort_state_kept", tgt_state, w1);
    step();

    k0 = n_tclk;
    send(2'd3, '0, acc);
    wait_done(acc, lat, nlow);
    chk("reserved_latency", NB'(lat), NB'(1));
    chk("reserved_err", NB'(err), NB'(1));
    step();
    repeat (3) step();
    chk("reserved_no_tclk", NB'(n_tclk - k0), NB'(0));

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 9);
      rop = (n < 4) ? 2'd0 : (n < 8) ? 2'd1 : (n == 8) ? 2'd2 : 2'd3;
      send(rop, {$urandom, $urandom, $urandom, $urandom}, acc);
      wait_done(acc, lat, nlow);
      chk("rand_latency", NB'(lat), NB'(periods(rop) * PER + 1));
      step();
    end

    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pudding_dac_loader.md
Name: pudding_dac_loader

Overview:
- Host-side transmitter for the PUDDING 128-source current-DAC serial load interface; lives in the companion FPGA/test-harness RTL.
- Generates the target clock plus datum/shift/transfer/dir/enable pin sequences, so a 128-bit code is shifted into the DAC daisychain and committed to its state register.
- Reads the committed state back serially through the target's daisychain MSB output pin (uo_out[7]).
- Also issues target synchronous resets.

Parameters:
HALF_PERIOD, 2, clk cycles per tclk half-period; legal range 2..255.
NBITS, 128, daisychain length in bits.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  loader idle, command accepted when cmd_valid&cmd_ready
cmd_op  in  2  0=WRITE, 1=READ, 2=TRESET, 3=reserved
cmd_wdata  in  NBITS  code to write, captured on accept
dac_enable  in  1  requested DAC enable level (target ui_in[4])
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done for reserved op
rdata  out  NBITS  last readback word, valid from done of READ
busy  out  1  operation in progress
tclk  out  1  target clock
trst_n  out  1  target rst_n
t_datum  out  1  target ui_in[0]
t_shift  out  1  target ui_in[1]
t_transfer  out  1  target ui_in[2]
t_dir  out  1  target ui_in[3]
t_en  out  1  target ui_in[4]
t_sdo  in  1  target uo_out[7] (daisychain MSB)

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: tclk=0, trst_n=1, t_datum=t_shift=t_transfer=t_dir=t_en=0, done=err=busy=0, cmd_ready=1, rdata=0, FSM=IDLE.
- Reset mid-operation aborts immediately to the reset values; no done is issued.
- Target timing model: the target samples pins on tclk rising edge.
  - shift=1 with transfer=0: daisychain <= {daisychain[126:0], datum}.
  - transfer=1, dir=1: state <= daisychain.
  - transfer=1, dir=0: daisychain <= state.
  - transfer has priority over shift.
- tclk period structure:
  - A period is HALF_PERIOD cycles low followed by HALF_PERIOD cycles high.
  - All t_* outputs are registered and change only in the first cycle of a low phase.
  - t_sdo is sampled in the last cycle of a high phase.
  - tclk is held at 0 in IDLE.
- t_en is updated from dac_enable at every low-phase start, and also every cycle in IDLE.
- FSM states: IDLE, WRITE_SHIFT, WRITE_COMMIT, READ, TRESET, FINISH.
- Accept: in IDLE with cmd_valid=1, latch cmd_op and cmd_wdata, drop cmd_ready, raise busy, start the first low phase next cycle.
  - cmd_valid while busy is ignored; there is no queuing.
- WRITE:
  - Periods k=0..NBITS-1: t_shift=1, t_transfer=0, t_datum=wdata[NBITS-1-k] (MSB first).
  - Period NBITS: t_shift=0, t_transfer=1, t_dir=1.
  - Total NBITS+1 periods.
- READ:
  - Period 0: t_transfer=1, t_dir=0, t_shift=0; sample t_sdo into rdata[NBITS-1].
  - Periods k=1..NBITS-1: t_shift=1, t_datum=0; sample into rdata[NBITS-1-k].
  - Total NBITS periods.
  - rdata is built in a shadow register and copied to the rdata output in the done cycle.
  - The target state register is not modified; its daisychain is left shifted.
- TRESET: 2 periods with trst_n=0, all other control pins 0; trst_n returns to 1 at FINISH.
- Reserved op: no tclk activity; done=1 and err=1 in the cycle after accept.
- FINISH:
  - Occurs after the last high phase completes.
  - t_shift=t_transfer=t_dir=t_datum=0, tclk=0.
  - done pulses one cycle; cmd_ready=1 and busy=0 in the same cycle.
  - A new command can be accepted in that cycle.
- Latency from the accept edge to the done cycle is P*2*HALF_PERIOD+1 clk cycles.
  - P=129 for WRITE, 128 for READ, 2 for TRESET.
- Counters:
  - Bit counter is 8 bits; the last period is detected by compare, never by wrap.
  - Phase counter wraps at HALF_PERIOD-1.

Test Plan:
- Behavioural PUDDING target model on tclk; TRESET -> trst_n low exactly 4*HALF_PERIOD cycles; target daisychain and state == 0; done once.
- WRITE cmd_wdata=128'h8000...0001 -> target state == 128'h8000...0001; exactly 128 shift periods plus 1 commit period with t_dir=1; done 517 cycles after accept (HALF_PERIOD=2).
- WRITE 128'hDEADBEEF_0123_4567_89AB_CDEF_F0E1D2C3, then READ -> rdata equals the written word; target state unchanged; READ done 513 cycles after accept.
- Hold cmd_valid with a second op during busy -> ignored; issued again in the done cycle -> accepted with no idle gap.
- Assert rst_n=0 mid-WRITE at bit 60 -> next cycle all outputs at reset values; no done; target state holds its previous value.
- cmd_op=3 -> done=err=1 one cycle after accept; tclk never toggles. Toggling dac_enable during WRITE -> t_en changes only at low-phase starts.
